// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared multdiv operator and arbiter state types
// Purpose: types shared by the multdiv arbiter and its round-robin helper.
//   md_op_e     : operator presented to the multdiv unit
//   arb_state_e : ownership state of the shared multdiv unit
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_BUSY  = 2'b01,
        ARB_ABORT = 2'b10
    } arb_state_e;

endpackage

// File: rtl/ibex_rr_arbiter.sv
// rtl/ibex_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: pick the first asserted request at or after the pointer, wrapping.
// Ports:
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle
//   gnt_o   : one-hot grant
//   idx_o   : index of the granted request
//   valid_o : some request was granted
module ibex_rr_arbiter #(
    parameter int NumReq = 2,
    localparam int IdxW  = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    // One spare bit so ptr + offset cannot overflow before the wrap compare;
    // the compare against NumReq keeps non-power-of-two counts correct.
    logic [IdxW:0]   sum;
    logic [IdxW-1:0] k;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        k       = '0;
        for (int i = 0; i < NumReq; i++) begin
            sum = {1'b0, ptr_i} + (IdxW+1)'(i);
            if (sum >= (IdxW+1)'(NumReq)) begin
                sum = sum - (IdxW+1)'(NumReq);
            end
            k = sum[IdxW-1:0];
            if (!valid_o && req_i[k]) begin
                valid_o  = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/ibex_multdiv_arbiter.sv
// rtl/ibex_multdiv_arbiter.sv - shares one multdiv unit between NumReq requesters
// Purpose: owns the multdiv unit for one whole operation, routes the result back
// to the owner and supports per-owner abort.
// Ports:
//   clk_i, rst_i                    : clock, async active-high reset
//   req_valid_i/req_ready_o         : per-requester request handshake
//   req_op_i, req_signed_mode_i     : per-requester operator and signed mode
//   req_operand_a_i/b_i             : per-requester operands
//   kill_i                          : per-requester abort of its own operation
//   rsp_valid_o/rsp_ready_i         : per-requester result handshake
//   rsp_result_o                    : shared result bus
//   busy_o                          : unit owned (BUSY or ABORT)
//   md_*_o                          : enables, selects, operator, operands to the unit
//   md_ready_id_o                   : owner ready, forwarded to the unit
//   md_valid_i, md_result_i         : unit result
module ibex_multdiv_arbiter
    import ibex_pkg::*;
#(
    parameter int NumReq = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_valid_i,
    output logic [NumReq-1:0] req_ready_o,
    input  md_op_e            req_op_i          [NumReq],
    input  logic [1:0]        req_signed_mode_i [NumReq],
    input  logic [31:0]       req_operand_a_i   [NumReq],
    input  logic [31:0]       req_operand_b_i   [NumReq],
    input  logic [NumReq-1:0] kill_i,
    output logic [NumReq-1:0] rsp_valid_o,
    input  logic [NumReq-1:0] rsp_ready_i,
    output logic [31:0]       rsp_result_o,
    output logic              busy_o,
    output logic              md_mult_en_o,
    output logic              md_div_en_o,
    output logic              md_mult_sel_o,
    output logic              md_div_sel_o,
    output md_op_e            md_operator_o,
    output logic [1:0]        md_signed_mode_o,
    output logic [31:0]       md_operand_a_o,
    output logic [31:0]       md_operand_b_o,
    output logic              md_ready_id_o,
    input  logic              md_valid_i,
    input  logic [31:0]       md_result_i
);

    localparam int IdxW = $clog2(NumReq);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] owner_q;
    logic [IdxW-1:0] owner_next;
    md_op_e          op_q;
    logic [1:0]      sm_q;
    logic [31:0]     a_q, b_q;

    logic [NumReq-1:0] gnt;
    logic [IdxW-1:0]   gnt_idx;
    logic              gnt_valid;
    logic              accept;
    logic              is_mult;

    ibex_rr_arbiter #(
        .NumReq (NumReq)
    ) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (rr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    assign accept     = (state_q == ARB_IDLE) && gnt_valid;
    assign owner_next = (owner_q == IdxW'(NumReq-1)) ? '0 : owner_q + IdxW'(1);
    assign is_mult    = (op_q == MD_OP_MULL) || (op_q == MD_OP_MULH);
    assign busy_o     = (state_q != ARB_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            op_q    <= MD_OP_MULL;
            sm_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (accept) begin
                owner_q <= gnt_idx;
                op_q    <= req_op_i[gnt_idx];
                sm_q    <= req_signed_mode_i[gnt_idx];
                a_q     <= req_operand_a_i[gnt_idx];
                b_q     <= req_operand_b_i[gnt_idx];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        rr_d             = rr_q;
        req_ready_o      = '0;
        rsp_valid_o      = '0;
        rsp_result_o     = '0;
        md_mult_en_o     = 1'b0;
        md_div_en_o      = 1'b0;
        md_mult_sel_o    = 1'b0;
        md_div_sel_o     = 1'b0;
        md_operator_o    = MD_OP_MULL;
        md_signed_mode_o = '0;
        md_operand_a_o   = '0;
        md_operand_b_o   = '0;
        md_ready_id_o    = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                req_ready_o = gnt;
                if (gnt_valid) begin
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                md_mult_en_o     = is_mult;
                md_mult_sel_o    = is_mult;
                md_div_en_o      = !is_mult;
                md_div_sel_o     = !is_mult;
                md_operator_o    = op_q;
                md_signed_mode_o = sm_q;
                md_operand_a_o   = a_q;
                md_operand_b_o   = b_q;
                md_ready_id_o    = rsp_ready_i[owner_q];
                rsp_result_o     = md_result_i;
                // Kill beats a same-cycle completion and suppresses the response.
                if (kill_i[owner_q]) begin
                    state_d = ARB_ABORT;
                end else begin
                    rsp_valid_o[owner_q] = md_valid_i;
                    if (md_valid_i && rsp_ready_i[owner_q]) begin
                        state_d = ARB_IDLE;
                        rr_d    = owner_next;
                    end
                end
            end
            ARB_ABORT: begin
                // One cycle with enables low returns the unit to its idle state.
                state_d = ARB_IDLE;
                rr_d    = owner_next;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: doc/ibex_multdiv_arbiter.md
# ibex_multdiv_arbiter

Shares one `ibex_multdiv_fast`/`ibex_multdiv_slow` instance between NumReq independent requesters, e.g. the ID stage and a coprocessor port. It sits in the EX block between the requesters and the multdiv unit's enable, select, operand and ready inputs. It owns the unit for the full duration of one operation, returns the result to the owning requester, and supports per-requester abort.

## Interface
Parameters:
- `NumReq`, default 2: number of requesters; legal range 2..4.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is asynchronous and active-high.
- `req_valid_i` in [NumReq]: request valid, per requester.
- `req_ready_o` out [NumReq]: request accepted this cycle.
- `req_op_i` in [NumReq] x `md_op_e`: MULL/MULH/DIV/REM.
- `req_signed_mode_i` in [NumReq] x 2: signed mode.
- `req_operand_a_i` in [NumReq] x 32: operand A.
- `req_operand_b_i` in [NumReq] x 32: operand B.
- `kill_i` in [NumReq]: abort that requester's in-flight operation.
- `rsp_valid_o` out [NumReq]: result valid, one-hot.
- `rsp_ready_i` in [NumReq]: requester takes the result.
- `rsp_result_o` out 32: shared result bus.
- `busy_o` out 1: unit owned.
- `md_mult_en_o`, `md_div_en_o`, `md_mult_sel_o`, `md_div_sel_o` out 1 each: unit enables and selects.
- `md_operator_o` out `md_op_e`: operator to the unit.
- `md_signed_mode_o` out 2: signed mode to the unit.
- `md_operand_a_o`, `md_operand_b_o` out 32 each: operands to the unit.
- `md_ready_id_o` out 1: drives the unit's `multdiv_ready_id_i`.
- `md_valid_i` in 1: unit result valid.
- `md_result_i` in 32: unit result.

## Operation
FSM `arb_state_e`, three states.

IDLE:
- Round-robin arbitration over `req_valid_i`, starting at pointer `rr_q`.
- The winner gets `req_ready_o`. The handshake is `req_valid_i & req_ready_o`.
- On the handshake, latch op, signed mode and both operands, plus owner index `owner_q`. Go to BUSY.
- No handshake: stay in IDLE.

BUSY:
- `md_mult_en_o`/`md_mult_sel_o` = 1 for MULL/MULH.
- `md_div_en_o`/`md_div_sel_o` = 1 for DIV/REM.
- `md_operator_o`, `md_signed_mode_o` and `md_operand_*_o` come from the latched registers.
- `md_ready_id_o = rsp_ready_i[owner_q]`.
- `rsp_valid_o[owner_q] = md_valid_i`, combinational. `rsp_result_o = md_result_i`.
- `md_valid_i & rsp_ready_i[owner_q]`: completion. Go to IDLE and set `rr_q = owner_q+1` (mod NumReq).
- `md_valid_i` without ready: hold. Enables stay high and the unit holds the result.
- `kill_i[owner_q]`: go to ABORT. Kill wins over a same-cycle completion; no response is issued.

ABORT:
- All enables and selects are 0 for exactly one cycle; this returns the unit to its idle state.
- Set `rr_q = owner_q+1`. Go to IDLE.

Rules in every state:
- `kill_i` of a non-owner is ignored.
- `req_valid_i` may drop before acceptance without error.
- `busy_o` = state != IDLE.
- No new request is accepted while BUSY or ABORT.

## Timing
- Reset: state IDLE, `rr_q`=0, `owner_q`=0, latched operands 0.
- Reset values of outputs: all `md_*` outputs 0, `rsp_valid_o`=0, `req_ready_o` reflects IDLE arbitration only, `busy_o`=0.
- Reset mid-operation drops the operation silently.
- Acceptance is at edge N. Enables are driven from cycle N+1.
- Response appears combinationally in the cycle `md_valid_i` rises. Total latency = 1 + unit latency.
- The next acceptance is possible in the cycle after completion, or the cycle after ABORT.
- `req_ready_o` depends combinationally on `req_valid_i` and the state only, never on `rsp_ready_i`.
- NumReq not a power of two: pointer wrap uses explicit compare-to-NumReq-1.

## Structure
- Add `arb_state_e` {ARB_IDLE, ARB_BUSY, ARB_ABORT} to `ibex_pkg`.
- Reuse `md_op_e` from `ibex_pkg`.
- One sub-module, `ibex_rr_arbiter`: combinational round-robin with inputs request vector and pointer, outputs one-hot grant and index.
- Top level holds the FSM, latches and muxes.

## Test plan
- Single MULL from req0, A=7, B=6, `rsp_ready_i` high → `rsp_valid_o`=2'b01 with `rsp_result_o`=42. The op is accepted one cycle after reset release and `busy_o` drops the cycle after completion.
- req0 and req1 both valid out of reset → req0 granted first. req1 is granted in the cycle after req0 completes; req0 re-requesting then loses.
- DIV from req1, A=-100, B=7, signed mode 2'b11, `rsp_ready_i[1]` held low 5 cycles after `md_valid_i` → enables stay high and result -14 is held stable. Completion happens on the first ready cycle.
- `kill_i[0]` mid-DIV → exactly one cycle with all enables 0, no `rsp_valid_o`. The next req1 operation, MULH of 0x80000000 by 2 (signed), returns 0xFFFFFFFF.
- `kill_i[owner]` asserted in the same cycle as `md_valid_i` → no response. ABORT is entered. `kill_i` of the non-owner during BUSY has no effect.
- `rst_i` asserted asynchronously mid-operation → all outputs return to reset values without waiting for a clock edge. After release, req0 has priority again.
